// File: rtl/bus_mem_slave_if.sv
// Request/response bus between the arbiter (master) and bus_mem_slave (slave).
// Optional macro BUS_MEM_SLAVE_ERR_EN adds the rsp_err response flag.
interface bus_mem_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ID_W-1:0]   req_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef BUS_MEM_SLAVE_ERR_EN
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_id, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_id, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_id, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_id, rsp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_id, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_id, rsp_rdata
  );
`endif
endinterface

// File: rtl/bus_mem_slave.sv
// Word-memory bus target with an in-order, fixed-latency response queue.
// Optional macro BUS_MEM_SLAVE_ERR_EN: out-of-range addresses flag rsp_err instead of aliasing.
module bus_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 2,
  parameter int MEM_WORDS   = 64,
  parameter int LATENCY     = 3,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_mem_slave_if.slave  bus,
  output logic            busy,
  output logic [15:0]     txn_count
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [3:0]       CNT_INIT = 4'(LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);

  typedef struct packed {
    logic              write;
`ifdef BUS_MEM_SLAVE_ERR_EN
    logic              err;
`endif
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] rdata;
    logic [3:0]        cnt;
  } entry_t;

  logic [DATA_W-1:0]    mem [MEM_WORDS];
  logic [MEM_WORDS-1:0] written_reg;
  entry_t               q_reg [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [OCC_W-1:0]     occ_reg;
  logic [OCC_W-1:0]     occ_next;
  logic                 ready_reg;
  logic [15:0]          txn_count_reg;

  logic                   push;
  logic                   pop;
  logic                   in_range;
  logic                   mem_we;
  logic [IDX_W-1:0]       idx;
  logic [DATA_W-1:0]      rd_data;
  logic [QUEUE_DEPTH-1:0] load_vec;
  entry_t                 new_entry;
  entry_t                 head;
  logic                   rsp_valid_int;

  assign push = bus.req_valid && ready_reg;
  assign pop  = rsp_valid_int && bus.rsp_ready;
  assign idx  = bus.req_addr[IDX_W-1:0];

`ifdef BUS_MEM_SLAVE_ERR_EN
  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);
  assign in_range = ({1'b0, bus.req_addr} < MEM_LIMIT);
`else
  assign in_range = 1'b1;
`endif

  assign mem_we = push && bus.req_write && in_range;
  // Clearing on reset is tracked by written_reg so the array itself needs no reset port.
  assign rd_data = (in_range && written_reg[idx]) ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      written_reg <= '0;
    end else if (mem_we) begin
      written_reg[idx] <= 1'b1;
    end
  end

  always_comb begin
    new_entry       = '0;
    new_entry.write = bus.req_write;
`ifdef BUS_MEM_SLAVE_ERR_EN
    new_entry.err   = !in_range;
`endif
    new_entry.id    = bus.req_id;
    new_entry.rdata = bus.req_write ? '0 : rd_data;
    new_entry.cnt   = CNT_INIT;
  end

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_load
    assign load_vec[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  // Every entry counts down on its own so a stalled head does not delay younger entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!rst_n) begin
        q_reg[i] <= '0;
      end else if (load_vec[i]) begin
        q_reg[i] <= new_entry;
      end else if (q_reg[i].cnt != 4'd0) begin
        q_reg[i].cnt <= q_reg[i].cnt - 4'd1;
      end
    end
  end

  always_comb begin
    occ_next = occ_reg;
    if (push && !pop) begin
      occ_next = occ_reg + OCC_W'(1);
    end else if (!push && pop) begin
      occ_next = occ_reg - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      ready_reg     <= 1'b0;
      txn_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg    <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
        txn_count_reg <= txn_count_reg + 16'd1;
      end
      occ_reg   <= occ_next;
      ready_reg <= (occ_next < OCC_FULL);
    end
  end

  assign head          = q_reg[rd_ptr_reg];
  assign rsp_valid_int = (occ_reg != '0) && (head.cnt == 4'd0);

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_write = rsp_valid_int ? head.write : 1'b0;
  assign bus.rsp_id    = rsp_valid_int ? head.id : '0;
  assign bus.rsp_rdata = rsp_valid_int ? head.rdata : '0;
`ifdef BUS_MEM_SLAVE_ERR_EN
  assign bus.rsp_err   = rsp_valid_int ? head.err : 1'b0;
`endif

  assign busy      = (occ_reg != '0);
  assign txn_count = txn_count_reg;
endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed self-checking bench for bus_mem_slave (default parameters, LATENCY=3, QUEUE_DEPTH=4).
module tb_bus_mem_slave;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ID_W   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] txn_count;
  int n_checks = 0;
  int n_fail   = 0;

  bus_mem_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  bus_mem_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .MEM_WORDS(64), .LATENCY(3), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_id    = '0;
  endtask

  task automatic drive_req(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [1:0] id);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_id    = id;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One complete request/response with rsp_ready held high.
  task automatic do_txn(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [1:0] id,
                        output logic rw, output logic [1:0] rid, output logic [31:0] rdata,
                        output logic rerr, output bit ok);
    ok = 1'b0; rw = 1'b0; rid = '0; rdata = '0; rerr = 1'b0;
    drive_req(w, a, d, id);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    if (bus.req_ready) begin
      tick();
      idle_inputs();
      for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
      if (bus.rsp_valid) begin
        ok    = 1'b1;
        rw    = bus.rsp_write;
        rid   = bus.rsp_id;
        rdata = bus.rsp_rdata;
`ifdef BUS_MEM_SLAVE_ERR_EN
        rerr  = bus.rsp_err;
`endif
      end
      tick();
    end
    idle_inputs();
    $display("txn w=%0b addr=%02h wdata=%08h id=%0d -> ok=%0b rsp_write=%0b rsp_id=%0d rdata=%08h err=%0b",
             w, a, d, id, ok, rw, rid, rdata, rerr);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_write !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_write: got %0b want 0", bus.rsp_write); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d want 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %08h want 0", bus.rsp_rdata); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL rst_txn_count: got %0d want 0", txn_count); end
`ifdef BUS_MEM_SLAVE_ERR_EN
    n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err: got %0b want 0", bus.rsp_err); end
`endif
    rst_n = 1'b1;
    tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 1", bus.req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    logic rw, rerr; logic [1:0] rid; logic [31:0] rdata; bit ok;
    do_reset();
    bus.rsp_ready = 1'b1;
    drive_req(1'b1, 8'h05, 32'hDEADBEEF, 2'd1);
    tick();
    idle_inputs();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge1: got %0b want 0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge2: got %0b want 0", bus.rsp_valid); end
    tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL lat_edge3: got %0b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 2'd1) begin n_fail++; $display("FAIL single_id: got %0d want 1", bus.rsp_id); end
    n_checks++; if (bus.rsp_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %0b want 1", bus.rsp_write); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL single_wr_rdata: got %08h want 0", bus.rsp_rdata); end
    $display("rsp id=%0d write=%0b rdata=%08h", bus.rsp_id, bus.rsp_write, bus.rsp_rdata);
    tick();
    n_checks++; if (txn_count !== 16'd1) begin n_fail++; $display("FAIL single_txn1: got %0d want 1", txn_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %0b want 0", busy); end
    do_txn(1'b0, 8'h05, 32'd0, 2'd2, rw, rid, rdata, rerr, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_rd_done: got %0b want 1", ok); end
    n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rd_data: got %08h want deadbeef", rdata); end
    n_checks++; if (rw !== 1'b0) begin n_fail++; $display("FAIL single_rd_write: got %0b want 0", rw); end
    n_checks++; if (rid !== 2'd2) begin n_fail++; $display("FAIL single_rd_id: got %0d want 2", rid); end
    n_checks++; if (txn_count !== 16'd2) begin n_fail++; $display("FAIL single_txn2: got %0d want 2", txn_count); end
  endtask

  task automatic test_back_to_back();
    logic       ws [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] as [6] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3};
    logic [31:0] ds [6] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    logic [1:0] ids [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_rd [6] = '{32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33};
    int got = 0, last_cyc = -1, gaps = 0, not_ready = 0;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 6) begin
        drive_req(ws[c], as[c], ds[c], ids[c]);
        if (!bus.req_ready) not_ready++;
      end else begin
        idle_inputs();
      end
      if (bus.rsp_valid) begin
        $display("rsp id=%0d write=%0b rdata=%08h cycle=%0d", bus.rsp_id, bus.rsp_write, bus.rsp_rdata, c);
        if (got < 6) begin
          n_checks++; if (bus.rsp_id !== ids[got]) begin n_fail++; $display("FAIL b2b_id[%0d]: got %0d want %0d", got, bus.rsp_id, ids[got]); end
          n_checks++; if (bus.rsp_write !== ws[got]) begin n_fail++; $display("FAIL b2b_write[%0d]: got %0b want %0b", got, bus.rsp_write, ws[got]); end
          n_checks++; if (bus.rsp_rdata !== exp_rd[got]) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %08h want %08h", got, bus.rsp_rdata, exp_rd[got]); end
        end
        if (last_cyc >= 0 && c != last_cyc + 1) gaps++;
        last_cyc = c;
        got++;
      end
      tick();
    end
    n_checks++; if (not_ready != 0) begin n_fail++; $display("FAIL b2b_ready: got %0d stalls want 0", not_ready); end
    n_checks++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got); end
    n_checks++; if (gaps != 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d want 0", gaps); end
    n_checks++; if (txn_count !== 16'd6) begin n_fail++; $display("FAIL b2b_txn: got %0d want 6", txn_count); end
  endtask

  task automatic test_backpressure();
    logic       ws [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] as [6] = '{8'd8, 8'd9, 8'd10, 8'd11, 8'd8, 8'd9};
    logic [31:0] ds [6] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
    logic [1:0] ids [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] exp_rd [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1};
    int sent = 0, got = 0;
    bit acc;
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_req(ws[sent], as[sent], ds[sent], ids[sent]);
      acc = bus.req_ready;
      tick();
      if (acc) sent++;
    end
    n_checks++; if (sent != 4) begin n_fail++; $display("FAIL bp_accepts: got %0d want 4", sent); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %0b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_valid: got %0b want 1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL bp_head_rdata: got %08h want 0", bus.rsp_rdata); end
    tick();
    tick();
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL bp_head_id_hold: got %0d want 0", bus.rsp_id); end
    n_checks++; if (bus.rsp_write !== 1'b1) begin n_fail++; $display("FAIL bp_head_write_hold: got %0b want 1", bus.rsp_write); end
    bus.rsp_ready = 1'b1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_pop_no_accept: got %0b want 0", bus.req_ready); end
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (sent < 6) drive_req(ws[sent], as[sent], ds[sent], ids[sent]);
      else idle_inputs();
      acc = bus.req_valid && bus.req_ready;
      if (bus.rsp_valid) begin
        $display("rsp id=%0d write=%0b rdata=%08h", bus.rsp_id, bus.rsp_write, bus.rsp_rdata);
        n_checks++; if (bus.rsp_id !== ids[got]) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want %0d", got, bus.rsp_id, ids[got]); end
        n_checks++; if (bus.rsp_rdata !== exp_rd[got]) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %08h want %08h", got, bus.rsp_rdata, exp_rd[got]); end
        got++;
      end
      tick();
      if (acc) sent++;
    end
    idle_inputs();
    n_checks++; if (got != 6) begin n_fail++; $display("FAIL bp_rsp_count: got %0d want 6", got); end
    n_checks++; if (sent != 6) begin n_fail++; $display("FAIL bp_sent: got %0d want 6", sent); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %0b want 0", busy); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_end: got %0b want 1", bus.req_ready); end
    n_checks++; if (txn_count !== 16'd6) begin n_fail++; $display("FAIL bp_txn: got %0d want 6", txn_count); end
  endtask

  task automatic test_push_pop();
    int pops = 0;
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 8'h00, 32'd0, 2'(i));
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL pp_head_valid: got %0b want 1", bus.rsp_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_occ3: got %0b want 1", bus.req_ready); end
    drive_req(1'b0, 8'h00, 32'd0, 2'd3);
    bus.rsp_ready = 1'b1;
    tick();
    idle_inputs();
    bus.rsp_ready = 1'b0;
    $display("push+pop cycle: busy=%0b req_ready=%0b txn_count=%0d", busy, bus.req_ready, txn_count);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pp_busy: got %0b want 1", busy); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after: got %0b want 1", bus.req_ready); end
    n_checks++; if (txn_count !== 16'd1) begin n_fail++; $display("FAIL pp_txn1: got %0d want 1", txn_count); end
    drive_req(1'b0, 8'h00, 32'd0, 2'd0);
    tick();
    idle_inputs();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL pp_full: got %0b want 0", bus.req_ready); end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && busy; c++) begin
      if (bus.rsp_valid) pops++;
      tick();
    end
    n_checks++; if (pops != 4) begin n_fail++; $display("FAIL pp_drain: got %0d want 4", pops); end
    n_checks++; if (txn_count !== 16'd5) begin n_fail++; $display("FAIL pp_txn5: got %0d want 5", txn_count); end
  endtask

  task automatic test_midreset();
    logic rw, rerr; logic [1:0] rid; logic [31:0] rdata; bit ok;
    int stale = 0;
    do_reset();
    do_txn(1'b1, 8'h10, 32'h77, 2'd1, rw, rid, rdata, rerr, ok);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, 8'h10, 32'd0, 2'(i));
      tick();
    end
    idle_inputs();
    tick(); tick();
    n_checks++; if (bus.rsp_rdata !== 32'h77) begin n_fail++; $display("FAIL mr_head_before: got %08h want 77", bus.rsp_rdata); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mr_req_ready: got %0b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mr_rsp_valid: got %0b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL mr_rsp_rdata: got %08h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.rsp_id !== 2'd0) begin n_fail++; $display("FAIL mr_rsp_id: got %0d want 0", bus.rsp_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy: got %0b want 0", busy); end
    n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("FAIL mr_txn: got %0d want 0", txn_count); end
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) stale++;
      tick();
    end
    n_checks++; if (stale != 0) begin n_fail++; $display("FAIL mr_stale: got %0d responses want 0", stale); end
    do_txn(1'b0, 8'h10, 32'd0, 2'd2, rw, rid, rdata, rerr, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mr_rd_done: got %0b want 1", ok); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL mr_mem_cleared: got %08h want 0", rdata); end
  endtask

  task automatic test_err();
    logic rw1, rw2, e1, e2; logic [1:0] id1, id2; logic [31:0] d1, d2; bit ok1, ok2;
    do_reset();
    do_txn(1'b1, 8'h80, 32'h55, 2'd2, rw1, id1, d1, e1, ok1);
    do_txn(1'b0, 8'h00, 32'd0, 2'd3, rw2, id2, d2, e2, ok2);
    n_checks++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin n_fail++; $display("FAIL err_done: got %0b%0b want 11", ok1, ok2); end
    n_checks++; if (id1 !== 2'd2) begin n_fail++; $display("FAIL err_wr_id: got %0d want 2", id1); end
`ifdef BUS_MEM_SLAVE_ERR_EN
    n_checks++; if (e1 !== 1'b1) begin n_fail++; $display("FAIL err_flag_oob: got %0b want 1", e1); end
    n_checks++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL err_flag_inrange: got %0b want 0", e2); end
    n_checks++; if (d2 !== 32'd0) begin n_fail++; $display("FAIL err_no_alias: got %08h want 0", d2); end
`else
    n_checks++; if (d2 !== 32'h55) begin n_fail++; $display("FAIL alias_rdata: got %08h want 55", d2); end
`endif
  endtask

  initial begin
    idle_inputs();
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop();
    test_midreset();
    test_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Downstream target of bus_arbiter: consumes the single granted request stream and performs reads/writes on an internal word memory.
- Returns in-order responses tagged with the originating master ID after a fixed, parameterised latency.
- Holds up to QUEUE_DEPTH outstanding transactions.
- Exposes busy and a completion counter so the bench or arbiter can derive done.

Parameters:
- ADDR_W, 8: request address width (word address).
- DATA_W, 32: data width.
- ID_W, 2: master ID width.
- MEM_WORDS, 64: memory depth; power of two, at most 2^ADDR_W.
- LATENCY, 3: cycles from acceptance edge to earliest rsp_valid; range 1..15.
- QUEUE_DEPTH, 4: maximum outstanding (accepted, not yet responded) transactions; range 1..8.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- req_valid, in, 1: arbiter has a granted request.
- req_ready, out, 1: slave can accept.
- req_write, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_wdata, in, DATA_W: write data.
- req_id, in, ID_W: originating master.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer accepts response.
- rsp_write, out, 1: echo of req_write.
- rsp_id, out, ID_W: echo of req_id.
- rsp_rdata, out, DATA_W: read data; 0 for writes.
- busy, out, 1: queue non-empty.
- txn_count, out, 16: responses completed since reset.

Behaviour:
- Reset (rst_n=0 sampled at posedge): queue emptied; pending responses dropped; all memory words cleared to 0.
- Reset output values: req_ready=0 while rst_n=0, then 1 from the first cycle after release; rsp_valid=0; rsp_write=0; rsp_id=0; rsp_rdata=0; busy=0; txn_count=0.
- Reset asserted mid-transaction discards everything; no response for a flushed entry is ever produced.
- Accept: req_valid && req_ready at a posedge.
  - req_ready = (occupancy < QUEUE_DEPTH); it depends only on registered state, never on req_valid or rsp_ready.
  - Full: req_ready=0 even if a pop occurs in the same cycle. There is no bypass.
- Memory index = req_addr modulo MEM_WORDS (low bits).
- At the accept edge:
  - A write updates memory.
  - A read captures mem[index] into the queue entry.
  - A read accepted the cycle after a write to the same address returns the new data. Accesses are strictly ordered.
- Each entry stores write, id, rdata and a countdown loaded with LATENCY-1. Every nonzero countdown decrements each cycle, independently of the head.
- Head entry:
  - rsp_valid=1 when the head entry's countdown==0.
  - LATENCY=1: response visible the cycle right after the accept edge.
  - LATENCY=3: response visible after the second following edge.
- Responses leave in acceptance order. A younger entry whose countdown expires waits behind the head.
- While rsp_valid && !rsp_ready, rsp_id, rsp_write and rsp_rdata hold stable.
- Pop on rsp_valid && rsp_ready. txn_count increments by 1 and wraps 0xFFFF -> 0.
- Simultaneous push and pop (not full): occupancy unchanged, both take effect.
- Back-to-back: with rsp_ready=1 held high, sustained throughput is one transaction per cycle after the initial LATENCY fill.
- busy = (occupancy != 0), registered-state derived.

Optional Feature:
- Macro: BUS_MEM_SLAVE_ERR_EN.
- When defined:
  - Adds output port rsp_err (1 bit, reset value 0).
  - A request with req_addr >= MEM_WORDS is accepted normally, but a write is suppressed and a read returns 0.
  - Its response carries rsp_err=1; all other responses carry rsp_err=0. Latency and ordering are unchanged.
- When undefined: no rsp_err port, and out-of-range addresses alias via modulo indexing.

Test Plan:
- Reset then single request: write id=1 addr=0x05 data=0xDEADBEEF; rsp_valid exactly 3 cycles after the accept edge with rsp_id=1, rsp_write=1, rsp_rdata=0. Then read addr=0x05 -> rsp_rdata=0xDEADBEEF, txn_count=2.
- Back-to-back ordering: writes data=0x11/0x22/0x33 to addr 1/2/3 (ids 0, 1, 2), then reads of addr 1/2/3 on consecutive cycles with rsp_ready=1. Six responses arrive in order with ids 0, 1, 2 then read data 0x11, 0x22, 0x33 on consecutive cycles; final txn_count=6.
- Backpressure/full: rsp_ready=0, issue 6 requests. req_ready drops after the 4th accept. rsp_valid holds the head (id, data) stable. Release rsp_ready: all remaining requests complete in order and req_ready returns to 1.
- Same-cycle push/pop at QUEUE_DEPTH-1 occupancy: occupancy stays 3 and busy stays 1. When full, a pop cycle does not accept a new request.
- Mid-operation reset: 3 outstanding, rst_n=0 for one edge. All outputs reach reset values, no stale response after release, and a read of a previously written address returns 0.
- BUS_MEM_SLAVE_ERR_EN with MEM_WORDS=64: write addr=0x80 data=0x55 -> rsp_err=1. Read addr=0x00 -> rsp_err=0, rdata unaffected (0). Without the macro, the same write aliases to index 0 and the subsequent read of 0x00 returns 0x55.
